// File: rtl/solver_dispatch_if.sv
// Job, solver-load and result signals of solver_dispatch.
// The master modport is the dispatcher; slave is the host/solver side.
interface solver_dispatch_if #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 16
);
  logic                       hdr_valid;
  logic                       hdr_ready;
  logic [LIMB_INDEX_BITS-1:0] hdr_num_limbs;
  logic [15:0]                hdr_iter_lim;
  logic [TAG_BITS-1:0]        hdr_tag;
  logic                       limb_valid;
  logic                       limb_ready;
  logic [LIMB_BITS-1:0]       limb_data;
  logic                       wr_real_en;
  logic                       wr_imag_en;
  logic [LIMB_INDEX_BITS-1:0] wr_ind;
  logic [LIMB_BITS-1:0]       c_wr_data;
  logic                       wr_num_limbs_en;
  logic [LIMB_INDEX_BITS-1:0] num_limbs_data;
  logic                       wr_iter_lim_en;
  logic [15:0]                iter_lim_data;
  logic                       start;
  logic                       out_ready;
  logic [15:0]                iteration_count;
  logic                       res_valid;
  logic                       res_ready;
  logic [TAG_BITS-1:0]        res_tag;
  logic [15:0]                res_count;
`ifdef SOLVER_DISPATCH_PERF_EN
  logic [31:0]                res_cycles;
`endif

  modport master (
    input  hdr_valid, hdr_num_limbs, hdr_iter_lim, hdr_tag,
    input  limb_valid, limb_data, out_ready, iteration_count, res_ready,
    output hdr_ready, limb_ready, wr_real_en, wr_imag_en, wr_ind, c_wr_data,
    output wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
    output res_valid, res_tag, res_count
`ifdef SOLVER_DISPATCH_PERF_EN
    , output res_cycles
`endif
  );

  modport slave (
    output hdr_valid, hdr_num_limbs, hdr_iter_lim, hdr_tag,
    output limb_valid, limb_data, out_ready, iteration_count, res_ready,
    input  hdr_ready, limb_ready, wr_real_en, wr_imag_en, wr_ind, c_wr_data,
    input  wr_num_limbs_en, num_limbs_data, wr_iter_lim_en, iter_lim_data, start,
    input  res_valid, res_tag, res_count
`ifdef SOLVER_DISPATCH_PERF_EN
    , input res_cycles
`endif
  );
endinterface

// File: rtl/solver_dispatch.sv
// Feeds one job (header, real limbs, imaginary limbs) into a solver and returns its tagged count.
// Optional SOLVER_DISPATCH_PERF_EN adds res_cycles (start-to-capture cycle count, saturating).
module solver_dispatch #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int TAG_BITS        = 16
) (
  input logic               clock,
  input logic               reset_n,
  solver_dispatch_if.master bus
);
  typedef enum logic [2:0] {IDLE, CONFIG, LOAD_RE, LOAD_IM, START, WAIT, RESULT} state_e;

  state_e                     state_q, state_d;
  logic [LIMB_INDEX_BITS-1:0] num_q, num_d, cnt_q, cnt_d, wr_ind_q, wr_ind_d;
  logic [15:0]                iter_q, iter_d, res_count_q, res_count_d;
  logic [TAG_BITS-1:0]        tag_q, tag_d, res_tag_q, res_tag_d;
  logic [LIMB_BITS-1:0]       wr_data_q, wr_data_d;
  logic                       drain_q, drain_d, first_q, first_d;
  logic                       hdr_ready_q, hdr_ready_d, limb_ready_q, limb_ready_d;
  logic                       wr_real_q, wr_real_d, wr_imag_q, wr_imag_d;
  logic                       cfg_en_q, cfg_en_d, start_q, start_d, res_valid_q, res_valid_d;
  logic                       hdr_acc, limb_acc;

  assign hdr_acc  = bus.hdr_valid & hdr_ready_q;
  assign limb_acc = bus.limb_valid & limb_ready_q;

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    iter_d      = iter_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    first_d     = 1'b0;
    wr_real_d   = 1'b0;
    wr_imag_d   = 1'b0;
    wr_ind_d    = wr_ind_q;
    wr_data_d   = wr_data_q;
    cfg_en_d    = 1'b0;
    start_d     = 1'b0;
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_count_d = res_count_q;
    case (state_q)
      IDLE: if (hdr_acc) begin
        num_d   = bus.hdr_num_limbs;
        iter_d  = bus.hdr_iter_lim;
        tag_d   = bus.hdr_tag;
        cnt_d   = '0;
        // A zero iteration limit still swallows the job's limbs, but never touches the solver.
        drain_d = (bus.hdr_iter_lim == 16'd0);
        state_d = (bus.hdr_iter_lim == 16'd0) ? LOAD_RE : CONFIG;
      end
      CONFIG: begin
        cfg_en_d = 1'b1;
        state_d  = LOAD_RE;
      end
      LOAD_RE, LOAD_IM: if (limb_acc) begin
        wr_real_d = ~drain_q & (state_q == LOAD_RE);
        wr_imag_d = ~drain_q & (state_q == LOAD_IM);
        wr_ind_d  = cnt_q;
        wr_data_d = bus.limb_data;
        if (cnt_q == num_q) begin
          cnt_d = '0;
          if (state_q == LOAD_RE) begin
            state_d = LOAD_IM;
          end else if (drain_q) begin
            state_d     = RESULT;
            res_valid_d = 1'b1;
            res_tag_d   = tag_q;
            res_count_d = 16'd0;
          end else begin
            state_d = START;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      START: begin
        start_d = 1'b1;
        first_d = 1'b1;
        state_d = WAIT;
      end
      // The solver's done level from the previous job is still up during the start cycle.
      WAIT: if (!first_q && bus.out_ready) begin
        res_valid_d = 1'b1;
        res_tag_d   = tag_q;
        res_count_d = bus.iteration_count;
        state_d     = RESULT;
      end
      RESULT: if (res_valid_q && bus.res_ready) begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    hdr_ready_d  = (state_d == IDLE);
    limb_ready_d = (state_d == LOAD_RE) || (state_d == LOAD_IM);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      num_q        <= '0;
      iter_q       <= '0;
      tag_q        <= '0;
      cnt_q        <= '0;
      drain_q      <= 1'b0;
      first_q      <= 1'b0;
      hdr_ready_q  <= 1'b0;
      limb_ready_q <= 1'b0;
      wr_real_q    <= 1'b0;
      wr_imag_q    <= 1'b0;
      wr_ind_q     <= '0;
      wr_data_q    <= '0;
      cfg_en_q     <= 1'b0;
      start_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      res_tag_q    <= '0;
      res_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      iter_q       <= iter_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      first_q      <= first_d;
      hdr_ready_q  <= hdr_ready_d;
      limb_ready_q <= limb_ready_d;
      wr_real_q    <= wr_real_d;
      wr_imag_q    <= wr_imag_d;
      wr_ind_q     <= wr_ind_d;
      wr_data_q    <= wr_data_d;
      cfg_en_q     <= cfg_en_d;
      start_q      <= start_d;
      res_valid_q  <= res_valid_d;
      res_tag_q    <= res_tag_d;
      res_count_q  <= res_count_d;
    end
  end

  assign bus.hdr_ready       = hdr_ready_q;
  assign bus.limb_ready      = limb_ready_q;
  assign bus.wr_real_en      = wr_real_q;
  assign bus.wr_imag_en      = wr_imag_q;
  assign bus.wr_ind          = wr_ind_q;
  assign bus.c_wr_data       = wr_data_q;
  assign bus.wr_num_limbs_en = cfg_en_q;
  assign bus.wr_iter_lim_en  = cfg_en_q;
  assign bus.num_limbs_data  = num_q;
  assign bus.iter_lim_data   = iter_q;
  assign bus.start           = start_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_tag         = res_tag_q;
  assign bus.res_count       = res_count_q;

`ifdef SOLVER_DISPATCH_PERF_EN
  logic [31:0] cyc_q, cyc_d, res_cycles_q, res_cycles_d;

  // Counting starts at 1 in the start cycle, so the capture cycle is included too.
  always_comb begin
    cyc_d        = cyc_q;
    res_cycles_d = res_cycles_q;
    if (state_q == START) begin
      cyc_d = '0;
    end else if (state_q == WAIT && cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end
    if (state_q == WAIT && state_d == RESULT) begin
      res_cycles_d = cyc_d;
    end else if ((state_q == LOAD_RE || state_q == LOAD_IM) && state_d == RESULT) begin
      res_cycles_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cyc_q        <= '0;
      res_cycles_q <= '0;
    end else begin
      cyc_q        <= cyc_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign bus.res_cycles = res_cycles_q;
`endif
endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch with a behavioural solver and write/result scoreboards.
module tb_solver_dispatch;
  localparam int LIB = 6;
  localparam int LB  = 32;
  localparam int TB  = 16;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  int   cfg_cnt = 0;
  int   start_cnt = 0;
  int   exp_num = 0;
  int   exp_iter = 0;
  int   solver_result = 0;
  int   solver_lat = 3;
  logic start_prev = 1'b0;
  logic [38:0] wr_q[$];
  logic [31:0] res_q[$];

  solver_dispatch_if #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TB)) bus ();

  solver_dispatch #(.LIMB_INDEX_BITS(LIB), .LIMB_BITS(LB), .TAG_BITS(TB)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Solver: done level drops the cycle after start, rises solver_lat cycles after start.
  initial begin
    bus.out_ready = 1'b0;
    bus.iteration_count = 16'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.out_ready = 1'b0;
      end else if (bus.start) begin
        @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (solver_lat - 1) @(negedge clk);
        if (rst_n) begin
          bus.out_ready = 1'b1;
          bus.iteration_count = solver_result[15:0];
        end
      end
    end
  end

  // Monitor for solver-facing writes, config pulses and start pulses.
  initial begin
    logic [38:0] e;
    forever begin
      @(negedge clk);
      if (bus.wr_real_en || bus.wr_imag_en) begin
        chk("wr_onehot", bus.wr_real_en & bus.wr_imag_en, 0);
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", 1, 0);
        end else begin
          e = wr_q.pop_front();
          chk("wr_kind", bus.wr_imag_en, e[38]);
          chk("wr_ind", bus.wr_ind, e[37:32]);
          chk("wr_data", bus.c_wr_data, e[31:0]);
        end
      end
      if (bus.wr_num_limbs_en || bus.wr_iter_lim_en) begin
        cfg_cnt++;
        chk("cfg_both_en", bus.wr_num_limbs_en & bus.wr_iter_lim_en, 1);
        chk("cfg_num", bus.num_limbs_data, exp_num);
        chk("cfg_iter", bus.iter_lim_data, exp_iter);
      end
      if (bus.start) begin
        start_cnt++;
        chk("start_single", start_prev, 0);
        chk("start_after_writes", wr_q.size(), 0);
      end
      start_prev = bus.start;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_hdr_ready"}, bus.hdr_ready, 0);
    chk({tag, "_limb_ready"}, bus.limb_ready, 0);
    chk({tag, "_wr_en"}, {bus.wr_real_en, bus.wr_imag_en, bus.wr_num_limbs_en, bus.wr_iter_lim_en}, 0);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_res_valid"}, bus.res_valid, 0);
    chk({tag, "_res_fields"}, {bus.res_tag, bus.res_count}, 0);
    chk({tag, "_data"}, {bus.wr_ind, bus.c_wr_data, bus.num_limbs_data, bus.iter_lim_data}, 0);
  endtask

  task automatic send_hdr(input int num, input int iter, input int tag);
    int n = 0;
    bus.hdr_valid = 1'b1;
    bus.hdr_num_limbs = num[LIB-1:0];
    bus.hdr_iter_lim = iter[15:0];
    bus.hdr_tag = tag[TB-1:0];
    while (!bus.hdr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.hdr_ready) chk("hdr_timeout", 0, 1);
    @(negedge clk);
    bus.hdr_valid = 1'b0;
  endtask

  task automatic send_comp(input bit imag, input int count, input int gap, input bit drain,
                           input logic [31:0] seed);
    int n;
    logic [31:0] d;
    logic [5:0]  ind;
    for (int i = 0; i < count; i++) begin
      repeat (gap) begin
        bus.limb_valid = 1'b0;
        @(negedge clk);
      end
      d = seed + i;
      ind = i[5:0];
      bus.limb_valid = 1'b1;
      bus.limb_data = d;
      if (!drain) wr_q.push_back({imag, ind, d});
      n = 0;
      while (!bus.limb_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!bus.limb_ready) chk("limb_timeout", 0, 1);
      @(negedge clk);
    end
    bus.limb_valid = 1'b0;
  endtask

  task automatic get_result(input int hold, input int exp_cycles);
    int n = 0;
    logic [31:0] e;
    bus.res_ready = (hold == 0);
    while (!bus.res_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) begin
      chk("res_timeout", 0, 1);
      bus.res_ready = 1'b0;
      return;
    end
    if (res_q.size() == 0) begin
      chk("res_unexpected", 1, 0);
      e = '0;
    end else begin
      e = res_q.pop_front();
    end
    chk("res_tag", bus.res_tag, e[31:16]);
    chk("res_count", bus.res_count, e[15:0]);
`ifdef SOLVER_DISPATCH_PERF_EN
    chk("res_cycles", bus.res_cycles, exp_cycles);
`else
    if (exp_cycles < 0) chk("res_cycles_arg", exp_cycles, 0);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_fields", {bus.res_tag, bus.res_count}, e);
      chk("hold_hdr_ready", bus.hdr_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("res_dropped", bus.res_valid, 0);
    chk("hdr_ready_after", bus.hdr_ready, 1);
    bus.res_ready = 1'b0;
  endtask

  task automatic run_job(input int num, input int iter, input int tag, input int gap,
                         input int hold, input int result, input int lat);
    int cfg0, st0;
    logic [31:0] seed;
    exp_num = num;
    exp_iter = iter;
    solver_result = result;
    solver_lat = lat;
    cfg0 = cfg_cnt;
    st0 = start_cnt;
    seed = $urandom;
    send_hdr(num, iter, tag);
    res_q.push_back({tag[15:0], (iter == 0) ? 16'd0 : result[15:0]});
    send_comp(1'b0, num + 1, gap, iter == 0, seed);
    send_comp(1'b1, num + 1, gap, iter == 0, ~seed);
    get_result(hold, (iter == 0) ? 0 : lat + 1);
    chk("cfg_pulses", cfg_cnt - cfg0, (iter == 0) ? 0 : 1);
    chk("start_pulses", start_cnt - st0, (iter == 0) ? 0 : 1);
    chk("writes_done", wr_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.hdr_valid = 1'b0;
    bus.hdr_num_limbs = '0;
    bus.hdr_iter_lim = '0;
    bus.hdr_tag = '0;
    bus.limb_valid = 1'b0;
    bus.limb_data = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_hdr_ready", bus.hdr_ready, 1);

    // Limbs ahead of their header must be held off.
    bus.limb_valid = 1'b1;
    bus.limb_data = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("early_limb_ready", bus.limb_ready, 0);
    end
    bus.limb_valid = 1'b0;

    run_job(2, 100, 16'h0012, 0, 0, 37, 5);
    // Solver done level is still high from the previous job here.
    run_job(2, 100, 16'h0012, 1, 0, 61, 4);
    run_job(3, 7, 16'hBEEF, 0, 10, 500, 3);
    run_job(1, 0, 16'h0077, 0, 0, 0, 3);
    run_job(1, 0, 16'h0078, 1, 2, 0, 3);
    run_job(63, 16'hFFFF, 16'h0099, 0, 0, 1234, 6);

    // Abandon a job in LOAD_IM with a reset.
    exp_num = 2;
    exp_iter = 10;
    send_hdr(2, 10, 16'h0033);
    send_comp(1'b0, 3, 0, 1'b0, 32'h1000_0000);
    send_comp(1'b1, 1, 0, 1'b0, 32'h2000_0000);
    @(negedge clk);
    chk("pre_reset_limb_ready", bus.limb_ready, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midjob_reset");
    wr_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(0, 5, 16'h0044, 0, 0, 9, 2);
    chk("no_stray_results", res_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/solver_dispatch.md
Name: solver_dispatch

Overview:
- Host-side feeder for one solver_control instance and its c limb register file.
- Accepts a job: header (num_limbs, iteration limit, tag), then real limbs, then imaginary limbs.
- Drives the solver's load/start interface, waits for completion, and returns the tagged iteration count on a valid/ready result port.
- One job in flight at a time.

Parameters:
LIMB_INDEX_BITS, 6, width of limb index and num_limbs
LIMB_BITS, 32, width of one c limb
TAG_BITS, 16, width of the job tag carried from header to result

Ports:
clock  in  1  clock
reset_n  in  1  synchronous active-low reset
hdr_valid  in  1  job header valid
hdr_ready  out  1  header accepted when hdr_valid & hdr_ready
hdr_num_limbs  in  LIMB_INDEX_BITS  highest limb index; job carries hdr_num_limbs+1 limbs per component
hdr_iter_lim  in  16  iteration limit
hdr_tag  in  TAG_BITS  job tag
limb_valid  in  1  limb word valid
limb_ready  out  1  limb accepted when limb_valid & limb_ready
limb_data  in  LIMB_BITS  limb word, index 0 first; real limbs then imaginary limbs
wr_real_en  out  1  write limb_data to c real file at wr_ind
wr_imag_en  out  1  write to c imaginary file at wr_ind
wr_ind  out  LIMB_INDEX_BITS  limb index for the write
c_wr_data  out  LIMB_BITS  limb write data
wr_num_limbs_en  out  1  load solver num_limbs
num_limbs_data  out  LIMB_INDEX_BITS  num_limbs value
wr_iter_lim_en  out  1  load solver iteration limit
iter_lim_data  out  16  iteration limit value
start  out  1  one-cycle solve start pulse
out_ready  in  1  solver done level (from solver)
iteration_count  in  16  solver result, valid while out_ready=1
res_valid  out  1  result valid, held until accepted
res_ready  in  1  result consumer ready
res_tag  out  TAG_BITS  tag of completed job
res_count  out  16  iteration count of completed job

Behaviour:
- All solver-facing and result outputs are registered.
- Reset: when reset_n=0 at a clock edge, state=IDLE and every output is 0, including hdr_ready, limb_ready, start and res_valid. Reset mid-job abandons the job with no result. The solver shares the reset.
- States: IDLE, CONFIG, LOAD_RE, LOAD_IM, START, WAIT, RESULT.
- IDLE:
  - hdr_ready=1.
  - On accept, latch num_limbs, iter_lim and tag; clear limb counter.
  - iter_lim==0 -> DRAIN (a sub-mode of LOAD_RE/LOAD_IM in which writes are suppressed); otherwise -> CONFIG.
- CONFIG (1 cycle): next cycle wr_num_limbs_en=wr_iter_lim_en=1 with the latched values; -> LOAD_RE.
- LOAD_RE / LOAD_IM:
  - limb_ready=1.
  - Each accept produces, next cycle, wr_real_en (LOAD_RE) or wr_imag_en (LOAD_IM), wr_ind=counter, c_wr_data=limb_data.
  - Counter increments per accept. When an accept occurs with counter==num_limbs, the counter clears and the state advances LOAD_RE->LOAD_IM->START.
  - limb_valid=0 stalls with no write; enables are 0 in cycles without an accept.
  - num_limbs = 2^LIMB_INDEX_BITS-1 is legal; compare on equality, no overflow.
- START: start=1 for exactly one cycle, asserted the cycle after the final imaginary write enable; -> WAIT.
- WAIT:
  - out_ready is ignored in the first WAIT cycle, because the solver's stale done level clears one cycle after start.
  - Afterwards, out_ready=1 -> capture iteration_count into res_count; -> RESULT.
- RESULT:
  - res_valid=1 with res_tag and res_count stable until res_valid & res_ready; -> IDLE. hdr_ready is 1 again the cycle after.
  - hdr_ready=0 and limb_ready=0 throughout WAIT and RESULT.
- iter_lim==0 path:
  - CONFIG, writes and start are all skipped; all 2*(num_limbs+1) limbs are still consumed and discarded.
  - Then RESULT with res_count=0.
- Ordering: limbs arriving before their header are not accepted (limb_ready=0 in IDLE).
- Simultaneous res_ready with res_valid rising: accepted that cycle; no bubble is required beyond the return to IDLE.

Optional Feature:
SOLVER_DISPATCH_PERF_EN
- Defined:
  - Adds output res_cycles [31:0]: cycles from the start pulse to the out_ready capture, inclusive of the start cycle.
  - The counter saturates at 0xFFFFFFFF, resets to 0, and is valid with res_valid.
  - For iter_lim==0 jobs, res_cycles=0.
- Not defined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Header num_limbs=2, iter_lim=100, tag=0x12; limbs R0..R2, I0..I2 back-to-back -> one CONFIG write (num_limbs 2, limit 100); wr_real_en at wr_ind 0,1,2; wr_imag_en at 0,1,2; single start pulse; solver model returns 37 -> res_tag=0x12, res_count=37.
- Same job with limb_valid toggling every other cycle -> exactly 6 writes with correct indices/data; start only after the last imaginary write.
- res_ready held low 10 cycles after completion -> res_valid and fields stable for all 10 cycles; hdr_ready=0 throughout; hdr_ready=1 the cycle after acceptance.
- iter_lim=0, num_limbs=1 -> 4 limbs consumed, no write/start/config enables, res_count=0.
- Stale out_ready=1 held from the previous job at start -> no capture in the first WAIT cycle; capture only on the next rising completion.
- reset_n low during LOAD_IM -> all outputs 0 next cycle; a new header is accepted after release and completes normally.
